hw_accel_s2mm_framer: RTL and testbench

HW_ACCEL_S2MM_FRAMER -- requirements
Module: hw_accel_s2mm_framer

---
 rtl/hw_accel_s2mm_framer.sv | 172 +++++++++++++++++
 tb/tb_hw_accel_s2mm_framer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_accel_s2mm_framer.sv
// hw_accel_s2mm_framer
// Frames an accelerator output stream into fixed-size frames for a DMA S2MM
// channel. Every frame is FRAME_WIDTH*FRAME_HEIGHT beats. Short frames are
// forwarded with m_last on the early s_last. Long frames are cut at N beats,
// and the excess beats are dropped until the upstream s_last arrives.
//
// Ports
//   clk, rstn     : clock, synchronous active-low reset
//   enable        : level, permits acceptance of new frames
//   clear_err     : pulse, clears the sticky error flags
//   s_valid/s_ready/s_data/s_last : upstream stream
//   m_valid/m_ready/m_data/m_last : downstream stream
//   frame_done    : one-cycle pulse in the cycle after an m_last beat is
//                   accepted downstream
//   frame_count   : completed frames, wraps at 16 bits
//   err_short     : sticky, a frame ended before N beats
//   err_long      : sticky, a frame ran past N beats
//   busy          : FSM is in RUN or DROP
module hw_accel_s2mm_framer #(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_WIDTH  = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  clear_err,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  busy
);

  localparam int N     = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DROP
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;

  // Second buffer entry. The first entry is the m_* output register itself.
  logic                  sk_valid;
  logic [DATA_WIDTH-1:0] sk_data;
  logic                  sk_last;

  logic                  s_acc;
  logic                  push;
  logic                  pop;
  logic                  at_end;
  logic                  fwd_last;
  logic                  set_short;
  logic                  set_long;
  logic [1:0]            occ;
  logic [1:0]            occ_nxt;

  always_comb begin
    s_acc     = s_valid && s_ready;
    push      = s_acc && (state == ST_RUN);
    pop       = m_valid && m_ready;
    at_end    = (cnt == LAST_IDX);
    state_nxt = state;
    cnt_nxt   = cnt;
    fwd_last  = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (s_acc) begin
          if (s_last || at_end) begin
            fwd_last = 1'b1;
            cnt_nxt  = '0;
            if (s_last) begin
              set_short = !at_end;
              state_nxt = enable ? ST_RUN : ST_IDLE;
            end else begin
              set_long  = 1'b1;
              state_nxt = ST_DROP;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_DROP: begin
        if (s_acc && s_last) state_nxt = enable ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    occ     = {1'b0, m_valid} + {1'b0, sk_valid};
    occ_nxt = occ + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      sk_valid    <= 1'b0;
      sk_data     <= '0;
      sk_last     <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;

      // s_ready is registered from the next occupancy, so a push in the same
      // cycle as a pop leaves it asserted.
      s_ready <= (occ_nxt != 2'd2) && (state_nxt != ST_IDLE);
      busy    <= (state_nxt != ST_IDLE);

      // The skid entry captures every upstream beat; sk_valid decides whether
      // it holds a live beat.
      if (push) begin
        sk_data <= s_data;
        sk_last <= fwd_last;
      end

      if (!m_valid || pop) begin
        if (sk_valid) begin
          m_valid <= 1'b1;
          m_data  <= sk_data;
          m_last  <= sk_last;
        end else if (push) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_last  <= fwd_last;
        end else begin
          m_valid <= 1'b0;
        end
        // The skid entry stays occupied only when it moved to the output
        // and a new beat replaced it in the same cycle.
        sk_valid <= sk_valid && push;
      end else if (push) begin
        sk_valid <= 1'b1;
      end

      frame_done <= pop && m_last;
      if (pop && m_last) frame_count <= frame_count + 16'd1;

      err_short <= set_short || (err_short && !clear_err);
      err_long  <= set_long  || (err_long  && !clear_err);
    end
  end

endmodule

// File: tb/tb_hw_accel_s2mm_framer.sv
// Directed testbench for hw_accel_s2mm_framer with N = 4*2 = 8 beats per frame.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge, or 1 time unit after a rising edge.
module tb_hw_accel_s2mm_framer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        clear_err;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_short;
  logic        err_long;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] oq_data[$];
  logic        oq_last[$];
  int          fd_cnt = 0;

  logic        stall_q = 1'b0;
  logic [31:0] hold_d  = '0;
  logic        hold_l  = 1'b0;

  hw_accel_s2mm_framer #(
    .DATA_WIDTH  (32),
    .FRAME_WIDTH (4),
    .FRAME_HEIGHT(2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .clear_err  (clear_err),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .err_short  (err_short),
    .err_long   (err_long),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Records downstream handshakes, frame_done pulses, and data stability
  // during stalls.
  always @(negedge clk) begin
    if (stall_q && m_valid) begin
      checks++;
      if (m_data !== hold_d || m_last !== hold_l) begin
        errors++;
        $display("FAIL stall_hold: got %0h/%0b required %0h/%0b", m_data, m_last, hold_d, hold_l);
      end
    end
    stall_q = m_valid && !m_ready;
    hold_d  = m_data;
    hold_l  = m_last;
    if (m_valid && m_ready) begin
      oq_data.push_back(m_data);
      oq_last.push_back(m_last);
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %0h not accepted within 100 cycles", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic clear_out;
    oq_data.delete();
    oq_last.delete();
    fd_cnt = 0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; enable = 1'b0; clear_err = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    wait_cycles(3);
    checks++;
    if ({s_ready, m_valid, m_last, frame_done, err_short, err_long, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000000",
               {s_ready, m_valid, m_last, frame_done, err_short, err_long, busy});
    end
    checks++;
    if (m_data !== 32'h0 || frame_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got data=%0h count=%0d required 0/0", m_data, frame_count);
    end
    rstn = 1'b1;
    wait_cycles(2);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_enable: got s_ready=%b busy=%b required 0/0", s_ready, busy);
    end
  endtask

  task automatic test_full_frame;
    clear_out();
    enable = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'(i), i == 7);
      if (i == 0) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h0) begin
          errors++;
          $display("FAIL latency: got m_valid=%b data=%0h required 1/0", m_valid, m_data);
        end
      end
    end
    wait_cycles(4);
    checks++;
    if (oq_data.size() != 8) begin
      errors++;
      $display("FAIL full_count: got %0d required 8", oq_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (oq_data[i] !== 32'(i) || oq_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL full_beat%0d: got %0h/%0b required %0h/%0b", i, oq_data[i], oq_last[i], i, i == 7);
        end
      end
    end
    checks++;
    if (fd_cnt != 1 || frame_count !== 16'd1) begin
      errors++;
      $display("FAIL full_done: got pulses=%0d count=%0d required 1/1", fd_cnt, frame_count);
    end
    checks++;
    if (err_short !== 1'b0 || err_long !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_flags: got short=%b long=%b busy=%b required 0/0/1", err_short, err_long, busy);
    end
  endtask

  task automatic test_short_frame;
    clear_out();
    for (int i = 0; i < 5; i++) send_beat(32'h20 + 32'(i), i == 4);
    wait_cycles(4);
    checks++;
    if (oq_data.size() != 5) begin
      errors++;
      $display("FAIL short_count: got %0d required 5", oq_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (oq_data[i] !== 32'h20 + 32'(i) || oq_last[i] !== (i == 4)) begin
          errors++;
          $display("FAIL short_beat%0d: got %0h/%0b required %0h/%0b", i, oq_data[i], oq_last[i], 32'h20 + 32'(i), i == 4);
        end
      end
    end
    checks++;
    if (err_short !== 1'b1 || err_long !== 1'b0 || frame_count !== 16'd2 || fd_cnt != 1) begin
      errors++;
      $display("FAIL short_flags: got short=%b long=%b count=%0d pulses=%0d required 1/0/2/1",
               err_short, err_long, frame_count, fd_cnt);
    end
    clear_out();
    for (int i = 0; i < 8; i++) send_beat(32'h30 + 32'(i), i == 7);
    wait_cycles(4);
    checks++;
    if (oq_data.size() != 8) begin
      errors++;
      $display("FAIL short_next_count: got %0d required 8", oq_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (oq_data[i] !== 32'h30 + 32'(i) || oq_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL short_next_beat%0d: got %0h/%0b required %0h/%0b", i, oq_data[i], oq_last[i], 32'h30 + 32'(i), i == 7);
        end
      end
    end
    checks++;
    if (frame_count !== 16'd3) begin
      errors++;
      $display("FAIL short_next_fc: got %0d required 3", frame_count);
    end
  endtask

  task automatic test_long_frame;
    clear_out();
    for (int i = 0; i < 11; i++) send_beat(32'h40 + 32'(i), i == 10);
    wait_cycles(4);
    checks++;
    if (oq_data.size() != 8) begin
      errors++;
      $display("FAIL long_count: got %0d required 8", oq_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (oq_data[i] !== 32'h40 + 32'(i) || oq_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL long_beat%0d: got %0h/%0b required %0h/%0b", i, oq_data[i], oq_last[i], 32'h40 + 32'(i), i == 7);
        end
      end
    end
    checks++;
    if (err_long !== 1'b1 || frame_count !== 16'd4 || fd_cnt != 1) begin
      errors++;
      $display("FAIL long_flags: got long=%b count=%0d pulses=%0d required 1/4/1", err_long, frame_count, fd_cnt);
    end
    clear_out();
    for (int i = 0; i < 8; i++) send_beat(32'h50 + 32'(i), i == 7);
    wait_cycles(4);
    checks++;
    if (oq_data.size() != 8) begin
      errors++;
      $display("FAIL long_next_count: got %0d required 8", oq_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (oq_data[i] !== 32'h50 + 32'(i) || oq_last[i] !== (i == 7)) begin
          errors++;
          $display("FAIL long_next_beat%0d: got %0h/%0b required %0h/%0b", i, oq_data[i], oq_last[i], 32'h50 + 32'(i), i == 7);
        end
      end
    end
    checks++;
    if (frame_count !== 16'd5) begin
      errors++;
      $display("FAIL long_next_fc: got %0d required 5", frame_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pat;
    int occ;
    int sent;
    int cyc;
    logic acc;
    logic pp;
    pat  = 32'hC238_B1E4;
    occ  = 0;
    sent = 0;
    cyc  = 0;
    clear_out();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h100;
    s_last  = 1'b0;
    while (sent < 16 && cyc < 400) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      pp  = m_valid && m_ready;
      checks++;
      if (s_ready !== (occ < 2)) begin
        errors++;
        $display("FAIL bp_ready: cycle %0d got %b required %b (occupancy %0d)", cyc, s_ready, occ < 2, occ);
      end
      @(posedge clk);
      #1;
      occ = occ + int'(acc) - int'(pp);
      if (acc) begin
        sent++;
        s_data = 32'h100 + 32'(sent);
        s_last = (sent == 7 || sent == 15);
      end
      m_ready = pat[cyc % 32];
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    wait_cycles(4);
    checks++;
    if (oq_data.size() != 16) begin
      errors++;
      $display("FAIL bp_count: got %0d required 16", oq_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (oq_data[i] !== 32'h100 + 32'(i) || oq_last[i] !== (i == 7 || i == 15)) begin
          errors++;
          $display("FAIL bp_beat%0d: got %0h/%0b required %0h/%0b", i, oq_data[i], oq_last[i],
                   32'h100 + 32'(i), i == 7 || i == 15);
        end
      end
    end
    checks++;
    if (frame_count !== 16'd7 || fd_cnt != 2) begin
      errors++;
      $display("FAIL bp_done: got count=%0d pulses=%0d required 7/2", frame_count, fd_cnt);
    end
  endtask

  task automatic test_enable_drop;
    clear_out();
    for (int i = 0; i < 8; i++) begin
      send_beat(32'h60 + 32'(i), i == 7);
      if (i == 2) enable = 1'b0;
    end
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_idle: got s_ready=%b busy=%b required 0/0", s_ready, busy);
    end
    wait_cycles(3);
    s_valid = 1'b1;
    s_data  = 32'hEE;
    wait_cycles(3);
    checks++;
    if (s_ready !== 1'b0 || oq_data.size() != 8 || frame_count !== 16'd8) begin
      errors++;
      $display("FAIL en_frame: got s_ready=%b beats=%0d count=%0d required 0/8/8", s_ready, oq_data.size(), frame_count);
    end
    s_valid = 1'b0;
    if (oq_data.size() == 8) begin
      checks++;
      if (oq_data[7] !== 32'h67 || oq_last[7] !== 1'b1) begin
        errors++;
        $display("FAIL en_last: got %0h/%0b required 67/1", oq_data[7], oq_last[7]);
      end
    end
    clear_err = 1'b1;
    wait_cycles(1);
    clear_err = 1'b0;
    checks++;
    if (err_short !== 1'b0 || err_long !== 1'b0) begin
      errors++;
      $display("FAIL clear_err: got short=%b long=%b required 0/0", err_short, err_long);
    end
  endtask

  task automatic test_reset_mid;
    clear_out();
    enable  = 1'b1;
    m_ready = 1'b1;
    send_beat(32'h70, 1'b0);
    send_beat(32'h71, 1'b0);
    wait_cycles(1);
    m_ready = 1'b0;
    send_beat(32'h72, 1'b0);
    send_beat(32'h73, 1'b0);
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h72) begin
      errors++;
      $display("FAIL mid_full: got s_ready=%b m_valid=%b data=%0h required 0/1/72", s_ready, m_valid, m_data);
    end
    fd_cnt = 0;
    rstn = 1'b0;
    wait_cycles(1);
    checks++;
    if ({s_ready, m_valid, m_last, frame_done, err_short, err_long, busy} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b required 0000000",
               {s_ready, m_valid, m_last, frame_done, err_short, err_long, busy});
    end
    checks++;
    if (m_data !== 32'h0 || frame_count !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_values: got data=%0h count=%0d required 0/0", m_data, frame_count);
    end
    rstn = 1'b1;
    m_ready = 1'b1;
    wait_cycles(4);
    checks++;
    if (m_valid !== 1'b0 || fd_cnt != 0 || oq_data.size() != 2) begin
      errors++;
      $display("FAIL mid_discard: got m_valid=%b pulses=%0d beats=%0d required 0/0/2", m_valid, fd_cnt, oq_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_long_frame();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
